// File: rtl/reject_collector.sv
// Compacts accepted sampler lanes into LANES-wide coefficient RAM words until N are written.
// Optional rejected-lane statistics counter: define REJECT_COLLECT_STATS_EN.
module reject_collector #(
  parameter int LANES      = 4,
  parameter int CAND_BITS  = 12,
  parameter int N          = 256,
  parameter int WADDR_BITS = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        sample_tvalid,
  input  logic [LANES*CAND_BITS-1:0]  sample_tdata,
  input  logic [LANES-1:0]            acc_bus,
  output logic                        rnd_req,
  output logic                        busy,
  output logic                        wr_en,
  output logic [WADDR_BITS-1:0]       wr_addr,
  output logic [LANES*CAND_BITS-1:0]  wr_data,
  output logic                        done,
  output logic [15:0]                 rej_cnt
);

  localparam int CNT_BITS = $clog2(2*LANES);
  localparam int COMB     = 2*LANES-1;
  localparam logic [WADDR_BITS-1:0] LAST_ADDR = WADDR_BITS'(N/LANES-1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_e;

  state_e                      state_q, state_d;
  logic [CAND_BITS-1:0]        stage_q [LANES-1];
  logic [CAND_BITS-1:0]        stage_d [LANES-1];
  logic [CNT_BITS-1:0]         stage_cnt_q, stage_cnt_d;
  logic [WADDR_BITS-1:0]       waddr_q, waddr_d;
  logic [WADDR_BITS-1:0]       wr_addr_q, wr_addr_d;
  logic [LANES*CAND_BITS-1:0]  wr_data_q, wr_data_d;
  logic                        wr_en_q, wr_en_d;
  logic                        done_q, done_d;

  logic [CAND_BITS-1:0]        lane_w [LANES];
  logic [CAND_BITS-1:0]        comb [COMB];
  logic [CNT_BITS-1:0]         comb_cnt;
  logic [LANES*CAND_BITS-1:0]  word_w;
  logic                        consume;

  assign consume = (state_q == S_COLLECT) && sample_tvalid;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_w[gi]                           = sample_tdata[gi*CAND_BITS +: CAND_BITS];
      assign word_w[gi*CAND_BITS +: CAND_BITS]    = comb[gi];
    end
  endgenerate

  // Combined list: staged entries first, accepted lanes appended in lane order.
  always_comb begin
    for (int i = 0; i < COMB; i++) comb[i] = '0;
    for (int i = 0; i < LANES-1; i++) comb[i] = stage_q[i];
    comb_cnt = stage_cnt_q;
    for (int i = 0; i < LANES; i++) begin
      if (acc_bus[i]) begin
        comb[comb_cnt] = lane_w[i];
        comb_cnt       = comb_cnt + CNT_BITS'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    stage_cnt_d = stage_cnt_q;
    waddr_d     = waddr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_COLLECT;
          waddr_d     = '0;
          wr_addr_d   = '0;
          stage_cnt_d = '0;
        end
      end
      S_COLLECT: begin
        if (consume) begin
          if (comb_cnt >= CNT_BITS'(LANES)) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = waddr_q;
            wr_data_d   = word_w;
            waddr_d     = waddr_q + WADDR_BITS'(1);
            for (int i = 0; i < LANES-1; i++) stage_d[i] = comb[i+LANES];
            stage_cnt_d = comb_cnt - CNT_BITS'(LANES);
            // Last word: whatever is left over belongs to no polynomial.
            if (waddr_q == LAST_ADDR) begin
              state_d     = S_DONE;
              stage_cnt_d = '0;
              done_d      = 1'b1;
            end
          end else begin
            for (int i = 0; i < LANES-1; i++) stage_d[i] = comb[i];
            stage_cnt_d = comb_cnt;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stage_cnt_q <= '0;
      waddr_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < LANES-1; i++) stage_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      stage_cnt_q <= stage_cnt_d;
      waddr_q     <= waddr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      done_q      <= done_d;
      for (int i = 0; i < LANES-1; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign rnd_req = (state_q == S_COLLECT);
  assign busy    = (state_q != S_IDLE);
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;

`ifdef REJECT_COLLECT_STATS_EN
  localparam int RB = $clog2(LANES+1);
  logic [15:0]   rej_q, rej_d;
  logic [16:0]   rej_sum;
  logic [RB-1:0] n_rej;

  always_comb begin
    n_rej = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!acc_bus[i]) n_rej = n_rej + RB'(1);
    end
    rej_sum = {1'b0, rej_q} + 17'(n_rej);
    rej_d   = rej_q;
    if (state_q == S_IDLE && start) rej_d = '0;
    else if (consume)               rej_d = rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) rej_q <= '0;
    else     rej_q <= rej_d;
  end

  assign rej_cnt = rej_q;
`else
  assign rej_cnt = '0;
`endif

endmodule
